// File: rtl/dotp_pkg.sv
// rtl/dotp_pkg.sv - shared state encoding and default sizes for the dot-product scheduler
package dotp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        CLEAR,
        READ,
        FEED,
        WAIT,
        DONE
    } state_t;

    localparam int DEF_ELEMENT_WIDTH = 64;
    localparam int DEF_NO_OF_UNITS   = 8;
    localparam int DEF_NREQ          = 4;
    localparam int DEF_ADDR_W        = 10;
    localparam int DEF_TIMEOUT       = 1024;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - single-cycle round-robin arbiter, search starts after the last grantee
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            update,
    output logic [NREQ-1:0] grant
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] grant_idx;
    logic          found;
    int            idx;

    always_comb begin
        grant     = '0;
        grant_idx = ptr;
        found     = 1'b0;
        idx       = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = PW'(idx);
            end
        end
    end

    // Pointer starts at the top index so requester 0 wins the first round.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= PW'(NREQ - 1);
        end else if (update && found) begin
            ptr <= grant_idx;
        end
    end

endmodule

// File: rtl/dotp_scheduler.sv
// rtl/dotp_scheduler.sv - arbitrates requesters and streams chunk rows from memory into a dot-product engine
module dotp_scheduler
    import dotp_pkg::*;
#(
    parameter int element_width = DEF_ELEMENT_WIDTH,
    parameter int no_of_units   = DEF_NO_OF_UNITS,
    parameter int NREQ          = DEF_NREQ,
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int TIMEOUT       = DEF_TIMEOUT
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NREQ-1:0]                     req,
    input  logic [NREQ*ADDR_W-1:0]              req_base_a,
    input  logic [NREQ*ADDR_W-1:0]              req_base_b,
    input  logic [NREQ*32-1:0]                  req_len,
    output logic [NREQ-1:0]                     grant,
    output logic [NREQ-1:0]                     done,
    output logic [NREQ-1:0]                     error,
    output logic [element_width-1:0]            result,
    output logic                                busy,
    output logic                                mem_rd_en,
    output logic [ADDR_W-1:0]                   mem_addr_a,
    output logic [ADDR_W-1:0]                   mem_addr_b,
    input  logic [element_width*no_of_units-1:0] mem_rdata_a,
    input  logic [element_width*no_of_units-1:0] mem_rdata_b,
    output logic                                eng_clear,
    output logic [31:0]                         eng_total,
    output logic [element_width*no_of_units-1:0] eng_row_a,
    output logic [element_width*no_of_units-1:0] eng_row_b,
    output logic                                eng_load,
    input  logic                                eng_ready,
    input  logic                                eng_finish,
    input  logic [element_width-1:0]            eng_result
);

    localparam int ROW_W = element_width * no_of_units;
    localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_t            state, state_nxt;
    logic [NREQ-1:0]   arb_grant;
    logic [NREQ-1:0]   owner;
    logic              arb_update;
    logic [ADDR_W-1:0] base_a, base_b, sel_base_a, sel_base_b;
    logic [31:0]       len_r, sel_len, chunk_k, rem;
    logic [32:0]       nchunks;
    logic              last_chunk, timed_out, feed_first, keep;
    logic [TW-1:0]     timer;
    logic [ROW_W-1:0]  masked_a, masked_b, hold_a, hold_b;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .update (arb_update),
        .grant  (arb_grant)
    );

    always_comb begin
        sel_base_a = '0;
        sel_base_b = '0;
        sel_len    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_grant[i]) begin
                sel_base_a = req_base_a[i*ADDR_W +: ADDR_W];
                sel_base_b = req_base_b[i*ADDR_W +: ADDR_W];
                sel_len    = req_len[i*32 +: 32];
            end
        end
    end

    assign nchunks    = ({1'b0, len_r} + 33'(no_of_units - 1)) / 33'(no_of_units);
    assign rem        = len_r % 32'(no_of_units);
    assign last_chunk = ({1'b0, chunk_k} == nchunks - 33'd1);

    // Lanes past the end of a short final chunk must not reach the engine.
    always_comb begin
        masked_a = '0;
        masked_b = '0;
        keep     = 1'b1;
        for (int i = 0; i < no_of_units; i++) begin
            keep = !(last_chunk && (rem != 32'd0) && (32'(i) >= rem));
            if (keep) begin
                masked_a[i*element_width +: element_width] = mem_rdata_a[i*element_width +: element_width];
                masked_b[i*element_width +: element_width] = mem_rdata_b[i*element_width +: element_width];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        arb_update = 1'b0;
        case (state)
            IDLE:  if (|req) state_nxt = ARB;
            ARB: begin
                if (|req) begin
                    arb_update = 1'b1;
                    state_nxt  = (sel_len == 32'd0) ? DONE : CLEAR;
                end else begin
                    state_nxt = IDLE;
                end
            end
            CLEAR: state_nxt = READ;
            READ:  state_nxt = FEED;
            FEED:  if (eng_ready) state_nxt = last_chunk ? WAIT : READ;
            WAIT:  if (eng_finish || timer == TW'(TIMEOUT - 1)) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner      <= '0;
            result     <= '0;
            base_a     <= '0;
            base_b     <= '0;
            len_r      <= '0;
            chunk_k    <= '0;
            timer      <= '0;
            timed_out  <= 1'b0;
            feed_first <= 1'b0;
            hold_a     <= '0;
            hold_b     <= '0;
        end else begin
            feed_first <= (state == READ);
            case (state)
                ARB: begin
                    if (|req) begin
                        owner     <= arb_grant;
                        base_a    <= sel_base_a;
                        base_b    <= sel_base_b;
                        len_r     <= sel_len;
                        chunk_k   <= '0;
                        timer     <= '0;
                        timed_out <= 1'b0;
                        if (sel_len == 32'd0) result <= '0;
                    end
                end
                FEED: begin
                    // Read data is only valid on the first FEED cycle; keep a copy for stalls.
                    if (feed_first) begin
                        hold_a <= masked_a;
                        hold_b <= masked_b;
                    end
                    if (eng_ready && !last_chunk) chunk_k <= chunk_k + 32'd1;
                end
                WAIT: begin
                    if (eng_finish)                      result    <= eng_result;
                    else if (timer == TW'(TIMEOUT - 1))  timed_out <= 1'b1;
                    else                                 timer     <= timer + TW'(1);
                end
                DONE:    owner <= '0;
                default: ;
            endcase
        end
    end

    assign grant      = owner;
    assign done       = (state == DONE && !timed_out) ? owner : '0;
    assign error      = (state == DONE &&  timed_out) ? owner : '0;
    assign busy       = (state != IDLE);
    assign mem_rd_en  = (state == READ);
    assign mem_addr_a = base_a + chunk_k[ADDR_W-1:0];
    assign mem_addr_b = base_b + chunk_k[ADDR_W-1:0];
    assign eng_clear  = reset || (state == CLEAR);
    assign eng_total  = len_r;
    assign eng_row_a  = feed_first ? masked_a : hold_a;
    assign eng_row_b  = feed_first ? masked_b : hold_b;
    assign eng_load   = (state == FEED) && eng_ready;

endmodule
